// File: rtl/ram_dp_clr.sv
// ---------------------------------------------------------------------------
// ram_dp_clr
//
// Dual-port (one write port, one read port) RAM with a registered read port
// and a sequential clear engine. After reset, or when a clear is requested,
// the engine walks every address and writes zero. While it runs, `o_busy` is
// high and both ports are ignored.
//
// Parameters:
//   WIDTH  data word width in bits
//   DEPTH  address width in bits; the array holds 2**DEPTH words
//
// Ports:
//   i_clk        system clock, all state updates on the rising edge
//   i_reset      asynchronous, active-high reset
//   i_load       write enable
//   i_waddr      write address
//   i_in         write data
//   i_ren        read enable
//   i_raddr      read address
//   o_out        registered read data (holds when no read is accepted)
//   o_out_valid  high for one cycle when o_out carries data from a read
//   i_clear      request to zero the whole array
//   o_busy       clear engine active; write and read ports are ignored
//
// Optional build macro:
//   RAM_BYPASS_EN  when defined, a read and a write to the same address in
//                  the same cycle return the new write data (write-first).
//                  When undefined, the old contents are returned
//                  (read-first).
// ---------------------------------------------------------------------------
module ram_dp_clr #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [DEPTH-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_ren,
  input  logic [DEPTH-1:0] i_raddr,
  output logic [WIDTH-1:0] o_out,
  output logic             o_out_valid,
  input  logic             i_clear,
  output logic             o_busy
);

  localparam int NWORDS = 1 << DEPTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t             r_state;
  logic [DEPTH-1:0]   r_ctr;
  logic [WIDTH-1:0]   r_out;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_mem [NWORDS];

  logic               w_idle;
  logic               w_last;
  logic [WIDTH-1:0]   w_rdata;

  assign w_idle = (r_state == ST_IDLE);
  assign w_last = (r_ctr == DEPTH'(NWORDS - 1));

  // Read data source. With bypass, a same-cycle write to the address being
  // read is forwarded so the reader sees the new word.
`ifdef RAM_BYPASS_EN
  assign w_rdata = (i_load && (i_waddr == i_raddr)) ? i_in : r_mem[i_raddr];
`else
  assign w_rdata = r_mem[i_raddr];
`endif

  // Control FSM, clear counter and registered read port. The counter is
  // left at zero whenever the engine finishes (it wraps on the last
  // address), but is forced to zero again on a clear request for safety.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_CLEAR;
      r_ctr       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_out_valid <= 1'b0;
          r_ctr       <= r_ctr + 1'b1;
          if (w_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          if (i_ren) begin
            r_out       <= w_rdata;
            r_out_valid <= 1'b1;
          end else begin
            r_out_valid <= 1'b0;
          end
          if (i_clear) begin
            r_state <= ST_CLEAR;
            r_ctr   <= '0;
          end
        end
      endcase
    end
  end

  // Storage array. It has no reset of its own; the clear engine is the only
  // thing that zeroes it. A write in the same cycle as a clear request still
  // lands, and is then wiped by the engine.
  always_ff @(posedge i_clk) begin
    if (!w_idle) begin
      r_mem[r_ctr] <= '0;
    end else if (i_load) begin
      r_mem[i_waddr] <= i_in;
    end
  end

  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;
  assign o_busy      = ~w_idle;

endmodule

// File: tb/tb_ram_dp_clr.sv
// ---------------------------------------------------------------------------
// tb_ram_dp_clr
//
// Directed self-checking bench for ram_dp_clr (WIDTH=16, DEPTH=3). A model
// array tracks expected contents; every accepted read pushes its expected
// word onto a scoreboard queue, which is popped when o_out_valid appears.
// ---------------------------------------------------------------------------
module tb_ram_dp_clr;

  localparam int WIDTH = 16;
  localparam int DEPTH = 3;
  localparam int NWORDS = 1 << DEPTH;

  logic             clk;
  logic             rst;
  logic             load;
  logic [DEPTH-1:0] waddr;
  logic [WIDTH-1:0] wdata;
  logic             ren;
  logic [DEPTH-1:0] raddr;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             clear;
  logic             busy;

  int               nAsserts;
  int               nFails;
  logic [WIDTH-1:0] expQ[$];
  logic [WIDTH-1:0] memModel[NWORDS];
  logic [WIDTH-1:0] lastOut;

  ram_dp_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_load(load),
    .i_waddr(waddr),
    .i_in(wdata),
    .i_ren(ren),
    .i_raddr(raddr),
    .o_out(rdata),
    .o_out_valid(rvalid),
    .i_clear(clear),
    .o_busy(busy)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of port activity. When the RAM is expected idle, the model is
  // updated and an accepted read pushes its expected word; otherwise the
  // ports must be ignored. Outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input string tag, input logic ld,
                               input logic [DEPTH-1:0] wa,
                               input logic [WIDTH-1:0] wd, input logic rd,
                               input logic [DEPTH-1:0] ra, input logic clr,
                               input logic expectIdle);
    logic             expValid;
    logic [WIDTH-1:0] expWord;
    load  = ld;
    waddr = wa;
    wdata = wd;
    ren   = rd;
    raddr = ra;
    clear = clr;
    expValid = 1'b0;
    if (expectIdle) begin
      if (rd) begin
        expWord = memModel[ra];
`ifdef RAM_BYPASS_EN
        if (ld && (wa == ra)) expWord = wd;
`endif
        expQ.push_back(expWord);
        expValid = 1'b1;
      end
      if (ld) memModel[wa] = wd;
      if (clr) begin
        for (int i = 0; i < NWORDS; i++) memModel[i] = '0;
      end
    end
    @(posedge clk);
    #1;
    load  = 1'b0;
    ren   = 1'b0;
    clear = 1'b0;
    checkOutput({tag, ".valid"}, 32'(rvalid), 32'(expValid));
    if (expValid) begin
      checkOutput({tag, ".sbDepth"}, 32'(expQ.size()), 32'd1);
      if (expQ.size() > 0) begin
        expWord = expQ.pop_front();
        checkOutput({tag, ".data"}, 32'(rdata), 32'(expWord));
        lastOut = expWord;
      end
    end else begin
      checkOutput({tag, ".hold"}, 32'(rdata), 32'(lastOut));
    end
  endtask

  // Count rising edges until busy drops, bounded, and check the length.
  task automatic waitIdle(input string tag, input int expEdges);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (rvalid !== 1'b0) checkOutput({tag, ".validInClear"}, 32'(rvalid), 32'd0);
    end
    checkOutput({tag, ".edges"}, 32'(n), 32'(expEdges));
    checkOutput({tag, ".outHeld"}, 32'(rdata), 32'(lastOut));
  endtask

  task automatic readAll(input string tag);
    for (int a = 0; a < NWORDS; a++) begin
      applyStimulus(tag, 1'b0, '0, '0, 1'b1, DEPTH'(a), 1'b0, 1'b1);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    nAsserts = 0;
    nFails   = 0;
    lastOut  = '0;
    for (int i = 0; i < NWORDS; i++) memModel[i] = '0;
    rst   = 1'b1;
    load  = 1'b0;
    waddr = '0;
    wdata = '0;
    ren   = 1'b0;
    raddr = '0;
    clear = 1'b0;

    // 1: reset state, clear length after release, array reads zero.
    #1;
    checkOutput("rst.out", 32'(rdata), 32'd0);
    checkOutput("rst.valid", 32'(rvalid), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd1);
    #11;
    rst = 1'b0;
    checkOutput("rel.busy", 32'(busy), 32'd1);
    waitIdle("rstClear", NWORDS);
    readAll("zeroAfterRst");

    // 2: write then read, then an idle cycle holds the output.
    applyStimulus("wr5", 1'b1, 3'd5, 16'hBEEF, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus("rd5", 1'b0, '0, '0, 1'b1, 3'd5, 1'b0, 1'b1);
    applyStimulus("idle", 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("rd5.value", 32'(rdata), 32'h0000BEEF);

    // 3: same-address collision, then the stored value is visible.
    applyStimulus("wr2", 1'b1, 3'd2, 16'h0042, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus("coll2", 1'b1, 3'd2, 16'h1234, 1'b1, 3'd2, 1'b0, 1'b1);
`ifdef RAM_BYPASS_EN
    checkOutput("coll2.value", 32'(rdata), 32'h00001234);
`else
    checkOutput("coll2.value", 32'(rdata), 32'h00000042);
`endif
    applyStimulus("rd2", 1'b0, '0, '0, 1'b1, 3'd2, 1'b0, 1'b1);
    checkOutput("rd2.value", 32'(rdata), 32'h00001234);

    // Different addresses in one cycle are independent.
    applyStimulus("wr3rd5", 1'b1, 3'd3, 16'h3333, 1'b1, 3'd5, 1'b0, 1'b1);
    applyStimulus("rd3", 1'b0, '0, '0, 1'b1, 3'd3, 1'b0, 1'b1);

    // 6: address boundaries, no aliasing between 0 and 7.
    applyStimulus("wr7", 1'b1, 3'd7, 16'h7777, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus("wr0", 1'b1, 3'd0, 16'h0001, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus("rd7", 1'b0, '0, '0, 1'b1, 3'd7, 1'b0, 1'b1);
    checkOutput("rd7.value", 32'(rdata), 32'h00007777);
    applyStimulus("rd0", 1'b0, '0, '0, 1'b1, 3'd0, 1'b0, 1'b1);
    checkOutput("rd0.value", 32'(rdata), 32'h00000001);

    // 4: fill, clear request (with a same-cycle read), ports ignored while busy.
    for (int a = 0; a < NWORDS; a++) begin
      applyStimulus("fillA5", 1'b1, DEPTH'(a), 16'hA5A5, 1'b0, '0, 1'b0, 1'b1);
    end
    applyStimulus("clrReq", 1'b0, '0, '0, 1'b1, 3'd6, 1'b1, 1'b1);
    checkOutput("clrReq.busy", 32'(busy), 32'd1);
    applyStimulus("busyWr", 1'b1, 3'd1, 16'hFFFF, 1'b1, 3'd1, 1'b0, 1'b0);
    waitIdle("reqClear", NWORDS - 1);
    readAll("zeroAfterClr");

    // 5: reset in the middle of a clear restarts the full sequence.
    for (int a = 0; a < NWORDS; a++) begin
      applyStimulus("fillB", 1'b1, DEPTH'(a), WIDTH'(16'h1111 * (a + 1)), 1'b0, '0, 1'b0, 1'b1);
    end
    applyStimulus("rd4pre", 1'b0, '0, '0, 1'b1, 3'd4, 1'b0, 1'b1);
    applyStimulus("clr2", 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus("midClr", 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    #1;
    lastOut = '0;
    checkOutput("midRst.valid", 32'(rvalid), 32'd0);
    checkOutput("midRst.busy", 32'(busy), 32'd1);
    checkOutput("midRst.out", 32'(rdata), 32'd0);
    #3;
    rst = 1'b0;
    waitIdle("rstRestart", NWORDS);
    readAll("zeroAfterMidRst");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
Parametrised successor to the single-port RAM: separate write and read ports, registered read with valid flag, and a sequential clear engine that zeroes every word after reset or on request. It serves as the data/screen memory building block in the Memory map. It is a drop-in for the old RAM once callers honour `busy` and `out_valid`.

Parameters:
WIDTH, 16, data word width in bits
DEPTH, 3, address width in bits; the array holds 2^DEPTH words

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
load  input  1  write enable, write port
waddr  input  DEPTH  write address
in  input  WIDTH  write data
ren  input  1  read enable, read port
raddr  input  DEPTH  read address
out  output  WIDTH  registered read data
out_valid  output  1  high for one cycle when `out` carries data from an accepted read
clear  input  1  request to zero the whole array
busy  output  1  clear engine active; write and read ports ignored

Behaviour:
- FSM has two states, CLEAR and IDLE; `busy` is high exactly when the state is CLEAR.
- A DEPTH-bit clear counter `ctr` drives the clear engine.
- Reset (asynchronous, immediate): state=CLEAR, ctr=0, out=0, out_valid=0, busy=1.
- Array contents are never reset directly; they are zeroed only by the clear engine.
- CLEAR: on each posedge, mem[ctr]<=0 and ctr<=ctr+1. On the edge that writes address 2^DEPTH-1, state<=IDLE and ctr wraps to 0.
- Clear duration: busy stays high for exactly 2^DEPTH rising edges after reset release. The first accepted load or read is on edge 2^DEPTH+1.
- During CLEAR: `load`, `ren` and `clear` are ignored (writes dropped); out_valid=0; `out` holds its last value.
- IDLE write: if load=1 at a posedge, mem[waddr]<=in.
- IDLE read: if ren=1 at a posedge, out<=mem[raddr] and out_valid<=1, giving 1-cycle latency. If ren=0, out_valid<=0 and `out` holds.
- Same-address read/write in the same cycle: read-first, so `out` gets the old word unless RAM_BYPASS_EN is defined.
- Different addresses in the same cycle: the write and the read are independent.
- `clear` sampled high in IDLE:
  - load and ren in that same cycle are still performed;
  - state<=CLEAR and ctr<=0 on that edge;
  - busy goes high after that edge and the clear takes 2^DEPTH edges.
- Reset asserted mid-clear: the sequence restarts from ctr=0 and runs a full 2^DEPTH edges after release.
- Address arithmetic is unsigned, DEPTH bits. ctr wraps 2^DEPTH-1→0; there are no out-of-range addresses.

Optional Feature:
RAM_BYPASS_EN
- Defined: write-first forwarding. A read in IDLE with load=1 and waddr==raddr sets out<=in; mem is updated as normal.
- Undefined: read-first, so `out` gets the pre-write contents.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset pulse, WIDTH=16, DEPTH=3 -> during reset out=0, out_valid=0, busy=1. After release, busy=1 for exactly 8 rising edges, then 0. Reads of addresses 0..7 all return 0x0000 with out_valid=1.
2. IDLE write 0xBEEF to waddr=5, then ren=1 with raddr=5 -> on the next edge out=0xBEEF and out_valid=1. With ren=0 on the following cycle, out_valid=0 and out stays 0xBEEF.
3. Address 2 holds 0x0042; same cycle load=1, waddr=2, in=0x1234, ren=1, raddr=2 -> out=0x0042 without RAM_BYPASS_EN, 0x1234 with it. A later read of address 2 returns 0x1234 in both builds.
4. Fill addresses 0..7 with 0xA5A5, pulse clear, then during busy load 0xFFFF to address 1 and ren address 1 -> busy high for 8 edges, out_valid stays 0, the write is dropped, and every address subsequently reads 0x0000.
5. During a clear, assert reset when ctr=4 -> out_valid=0 and busy=1 immediately. After release, busy lasts a full 8 edges, and addresses 0..7 read 0x0000.
6. Address boundary: write 0x7777 to address 7 and 0x0001 to address 0 -> reads return 0x7777 and 0x0001 respectively, with no aliasing.
